// File: rtl/mem_interface.sv
// Memory interface: MAR/MBR staging plus a request/acknowledge handshake with a
// bounded wait; a missing acknowledge ends in a sticky error and all-ones read data.
module mem_interface #(
    parameter int DW      = 8,
    parameter int AW      = 8,
    parameter int TIMEOUT = 15
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic [DW-1:0] bus_in,
    input  logic          mar_in,
    input  logic          mbr_in,
    input  logic          mbr_out,
    input  logic          rnw,
    input  logic          wmfc,
    input  logic          mem_ack,
    input  logic [DW-1:0] mem_rdata,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic          mem_req,
    output logic          mem_we,
    output logic [DW-1:0] bus_out,
    output logic          bus_oe,
    output logic          mfc,
    output logic          stall,
    output logic          err
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_DONE   = 2'd2,
        S_ERR    = 2'd3
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic [AW-1:0]   r_mar;
    logic [DW-1:0]   r_mbr;
    logic            r_op;
    logic [CW-1:0]   r_cnt;
    logic            r_err;
    logic            w_timeout;

    assign w_timeout = (r_cnt == CW'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // An acknowledge on the last allowed wait cycle still completes normally.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (wmfc) begin
                    w_next = S_ACCESS;
                end
            end
            S_ACCESS: begin
                if (mem_ack) begin
                    w_next = S_DONE;
                end else if (w_timeout) begin
                    w_next = S_ERR;
                end
            end
            S_DONE:  w_next = S_IDLE;
            S_ERR:   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        mem_addr  = r_mar;
        mem_wdata = r_mbr;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        stall     = 1'b0;
        mfc       = 1'b0;
        bus_oe    = mbr_out;
        bus_out   = mbr_out ? r_mbr : '0;
        err       = r_err;
        case (r_state)
            S_ACCESS: begin
                mem_req = 1'b1;
                mem_we  = ~r_op;
                stall   = 1'b1;
            end
            S_DONE:  mfc = 1'b1;
            S_ERR:   mfc = 1'b1;
            default: ;
        endcase
    end

    // MAR/MBR only accept bus loads in IDLE so they stay stable for a transaction.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_mar <= '0;
            r_mbr <= '0;
            r_op  <= 1'b1;
            r_cnt <= '0;
            r_err <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (mar_in) begin
                        r_mar <= bus_in[AW-1:0];
                    end
                    if (mbr_in) begin
                        r_mbr <= bus_in;
                    end
                    if (wmfc) begin
                        r_op  <= rnw;
                        r_cnt <= '0;
                    end
                end
                S_ACCESS: begin
                    if (mem_ack) begin
                        if (r_op) begin
                            r_mbr <= mem_rdata;
                        end
                    end else if (!w_timeout) begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                S_ERR: begin
                    r_err <= 1'b1;
                    if (r_op) begin
                        r_mbr <= '1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
